// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus bundle: the pipeline (A) and long-latency (B) writeback
// requests, long-latency issue, decode busy checks, the regfile write port and
// the conflict performance counter.
// master: the requesters / regfile side; slave: the arbiter.
interface regfile_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
);
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_rd;
  logic              iss_ready;

  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [31:0]       perf_conflicts;

  modport master (
    output a_valid, a_addr, a_data,
    input  a_ready,
    output b_valid, b_addr, b_data,
    input  b_ready,
    output iss_valid, iss_rd,
    input  iss_ready,
    output chk_addr1, chk_addr2,
    input  chk_busy1, chk_busy2,
    input  rf_we, rf_waddr, rf_wdata,
    input  perf_conflicts
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    output a_ready,
    input  b_valid, b_addr, b_data,
    output b_ready,
    input  iss_valid, iss_rd,
    output iss_ready,
    input  chk_addr1, chk_addr2,
    output chk_busy1, chk_busy2,
    output rf_we, rf_waddr, rf_wdata,
    output perf_conflicts
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Regfile writeback arbiter.
// Shares the single regfile write port between the in-order pipeline writeback
// (A, priority) and the long-latency unit writeback (B, starvation-protected),
// and keeps a busy scoreboard of long-latency destinations for decode RAW stalls.
// Optional build macro: WB_ARB_PERF_EN enables the 32-bit conflict counter;
// without it perf_conflicts is tied to zero.
module regfile_wb_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);

  localparam int         NREG       = 1 << ADDR_W;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        r_starve_cnt;
  logic [3:0]        w_starve_nxt;
  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;

  logic              w_a_grant;
  logic              w_b_grant;
  logic              w_iss_ready;

  logic              r_we_p1;
  logic [ADDR_W-1:0] r_waddr_p1;
  logic [DATA_W-1:0] r_wdata_p1;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  // Grant selection: A wins unless B has been refused STARVE_MAX cycles; nothing granted in reset
  always_comb begin
    w_b_grant   = !rst && bus.b_valid && (!bus.a_valid || (r_starve_cnt == STARVE_LIM));
    w_a_grant   = !rst && bus.a_valid && !w_b_grant;
    w_iss_ready = !r_busy[bus.iss_rd];
  end

  assign bus.a_ready   = w_a_grant;
  assign bus.b_ready   = w_b_grant;
  assign bus.iss_ready = w_iss_ready;
  assign bus.chk_busy1 = r_busy[bus.chk_addr1];
  assign bus.chk_busy2 = r_busy[bus.chk_addr2];

  // Starvation count: climbs while B waits (saturating), drops to 0 on B grant or B idle
  always_comb begin
    w_starve_nxt = '0;
    if (bus.b_valid && !w_b_grant) begin
      if (r_starve_cnt < STARVE_LIM) begin
        w_starve_nxt = r_starve_cnt + 4'd1;
      end else begin
        w_starve_nxt = r_starve_cnt;
      end
    end
  end

  // Write-port mux: the granted request is staged; address 0 is acknowledged but never written
  always_comb begin
    w_we_nxt    = 1'b0;
    w_waddr_nxt = r_waddr_p1;
    w_wdata_nxt = r_wdata_p1;
    if (w_b_grant && (bus.b_addr != '0)) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = bus.b_addr;
      w_wdata_nxt = bus.b_data;
    end else if (w_a_grant && (bus.a_addr != '0)) begin
      w_we_nxt    = 1'b1;
      w_waddr_nxt = bus.a_addr;
      w_wdata_nxt = bus.a_data;
    end
  end

  // Scoreboard update: B grant clears, accepted issue sets afterwards so a same-register set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_b_grant) begin
      w_busy_nxt[bus.b_addr] = 1'b0;
    end
    if (bus.iss_valid && w_iss_ready && (bus.iss_rd != '0)) begin
      w_busy_nxt[bus.iss_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Control state: starvation counter and scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_busy       <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Write register stage: regfile port driven one cycle after the grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_p1    <= 1'b0;
      r_waddr_p1 <= '0;
      r_wdata_p1 <= '0;
    end else begin
      r_we_p1    <= w_we_nxt;
      r_waddr_p1 <= w_waddr_nxt;
      r_wdata_p1 <= w_wdata_nxt;
    end
  end

  assign bus.rf_we    = r_we_p1;
  assign bus.rf_waddr = r_waddr_p1;
  assign bus.rf_wdata = r_wdata_p1;

`ifdef WB_ARB_PERF_EN
  logic [31:0] r_perf_cnt;

  // Conflict counter: cycles with both writeback sources requesting, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_cnt <= '0;
    end else if (bus.a_valid && bus.b_valid) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end

  assign bus.perf_conflicts = r_perf_cnt;
`else
  assign bus.perf_conflicts = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for single-cycle
// behaviour plus hand-written starvation and reset sequences.
module tb_regfile_wb_arbiter;

  localparam int ADDR_W     = 5;
  localparam int DATA_W     = 64;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  regfile_wb_arbiter #(
    .STARVE_MAX(STARVE_MAX),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        av;  logic [4:0] aa; logic [63:0] ad;
    logic        bv;  logic [4:0] ba; logic [63:0] bd;
    logic        iv;  logic [4:0] ir;
    logic [4:0]  c1;  logic [4:0] c2;
    logic        e_ar; logic e_br; logic e_ir; logic e_cb1; logic e_cb2;
    logic        e_we; logic [4:0] e_wa; logic [63:0] e_wd;
  } vec_t;

  vec_t vq[$];
  int checks   = 0;
  int failures = 0;
  int exp_perf = 0;

  function automatic vec_t mkv(
    input logic av, input logic [4:0] aa, input logic [63:0] ad,
    input logic bv, input logic [4:0] ba, input logic [63:0] bd,
    input logic iv, input logic [4:0] ir,
    input logic [4:0] c1, input logic [4:0] c2,
    input logic e_ar, input logic e_br, input logic e_ir,
    input logic e_cb1, input logic e_cb2,
    input logic e_we, input logic [4:0] e_wa, input logic [63:0] e_wd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.iv = iv; v.ir = ir; v.c1 = c1; v.c2 = c2;
    v.e_ar = e_ar; v.e_br = e_br; v.e_ir = e_ir;
    v.e_cb1 = e_cb1; v.e_cb2 = e_cb2;
    v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.chk_addr1 = '0; bus.chk_addr2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // B held against a continuously valid A: refused STARVE_MAX cycles, then granted
  task automatic starve_run(input string tag, input logic [63:0] bdata);
    bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 64'hA2;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = bdata;
    for (int k = 1; k <= STARVE_MAX; k++) begin
      #1;
      check($sformatf("%s wait%0d b_ready", tag, k), 64'(bus.b_ready), 64'd0);
      check($sformatf("%s wait%0d a_ready", tag, k), 64'(bus.a_ready), 64'd1);
      tick();
      check($sformatf("%s wait%0d rf_waddr", tag, k), 64'(bus.rf_waddr), 64'd2);
      exp_perf++;
    end
    #1;
    check($sformatf("%s grant b_ready", tag), 64'(bus.b_ready), 64'd1);
    check($sformatf("%s grant a_ready", tag), 64'(bus.a_ready), 64'd0);
    tick();
    exp_perf++;
    check($sformatf("%s grant rf_we", tag), 64'(bus.rf_we), 64'd1);
    check($sformatf("%s grant rf_waddr", tag), 64'(bus.rf_waddr), 64'd7);
    check($sformatf("%s grant rf_wdata", tag), bus.rf_wdata, bdata);
  endtask

  function automatic logic [63:0] perf_expect(input int n);
`ifdef WB_ARB_PERF_EN
    return 64'(n);
`else
    return 64'd0 + 64'(n - n);
`endif
  endfunction

  initial begin
    // reset with both requesters active: nothing may be granted
    idle();
    rst = 1'b1;
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 64'h33;
    bus.b_valid = 1'b1; bus.b_addr = 5'd4; bus.b_data = 64'h44;
    tick();
    #1;
    check("rst a_ready", 64'(bus.a_ready), 64'd0);
    check("rst b_ready", 64'(bus.b_ready), 64'd0);
    tick();
    check("rst rf_we", 64'(bus.rf_we), 64'd0);
    check("rst rf_waddr", 64'(bus.rf_waddr), 64'd0);
    check("rst rf_wdata", bus.rf_wdata, 64'd0);
    check("rst perf", 64'(bus.perf_conflicts), 64'd0);
    rst = 1'b0;
    idle();

    // av aa ad  bv ba bd  iv ir  c1 c2 | a_rdy b_rdy iss_rdy busy1 busy2 | we waddr wdata
    vq.push_back(mkv(1, 5, 64'h11,   0, 0,  64'h0,    0, 0,  9, 0,  1,0,1,0,0,  1, 5, 64'h11));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    1, 9,  9, 0,  0,0,1,0,0,  0, 5, 64'h11));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    1, 9,  9, 0,  0,0,0,1,0,  0, 5, 64'h11));
    vq.push_back(mkv(0, 0, 64'h0,    1, 9,  64'h99,   0, 0,  9, 0,  0,1,1,1,0,  1, 9, 64'h99));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    0, 0,  9, 0,  0,0,1,0,0,  0, 9, 64'h99));
    vq.push_back(mkv(1, 0, 64'hFF,   0, 0,  64'h0,    1, 0,  0, 0,  1,0,1,0,0,  0, 9, 64'h99));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    0, 0,  0, 0,  0,0,1,0,0,  0, 9, 64'h99));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    1, 12, 12, 0, 0,0,1,0,0,  0, 9, 64'h99));
    vq.push_back(mkv(0, 0, 64'h0,    1, 12, 64'h1212, 1, 12, 12, 0, 0,1,0,1,0,  1, 12, 64'h1212));
    vq.push_back(mkv(0, 0, 64'h0,    1, 12, 64'h2222, 1, 12, 12, 0, 0,1,1,0,0,  1, 12, 64'h2222));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    0, 0,  12, 9, 0,0,1,1,0,  0, 12, 64'h2222));
    vq.push_back(mkv(1, 4, 64'h44,   1, 12, 64'h3333, 0, 0,  12, 0, 1,0,1,1,0,  1, 4, 64'h44));
    vq.push_back(mkv(0, 0, 64'h0,    1, 12, 64'h3333, 0, 0,  12, 0, 0,1,1,1,0,  1, 12, 64'h3333));
    vq.push_back(mkv(0, 0, 64'h0,    0, 0,  64'h0,    0, 0,  12, 0, 0,0,1,0,0,  0, 12, 64'h3333));

    foreach (vq[i]) begin
      bus.a_valid = vq[i].av; bus.a_addr = vq[i].aa; bus.a_data = vq[i].ad;
      bus.b_valid = vq[i].bv; bus.b_addr = vq[i].ba; bus.b_data = vq[i].bd;
      bus.iss_valid = vq[i].iv; bus.iss_rd = vq[i].ir;
      bus.chk_addr1 = vq[i].c1; bus.chk_addr2 = vq[i].c2;
      if (vq[i].av && vq[i].bv) exp_perf++;
      #1;
      check($sformatf("v%0d a_ready", i), 64'(bus.a_ready), 64'(vq[i].e_ar));
      check($sformatf("v%0d b_ready", i), 64'(bus.b_ready), 64'(vq[i].e_br));
      check($sformatf("v%0d iss_ready", i), 64'(bus.iss_ready), 64'(vq[i].e_ir));
      check($sformatf("v%0d chk_busy1", i), 64'(bus.chk_busy1), 64'(vq[i].e_cb1));
      check($sformatf("v%0d chk_busy2", i), 64'(bus.chk_busy2), 64'(vq[i].e_cb2));
      tick();
      check($sformatf("v%0d rf_we", i), 64'(bus.rf_we), 64'(vq[i].e_we));
      check($sformatf("v%0d rf_waddr", i), 64'(bus.rf_waddr), 64'(vq[i].e_wa));
      check($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vq[i].e_wd);
    end
    idle();
    #1;
    check("vectors perf", 64'(bus.perf_conflicts), perf_expect(exp_perf));

    // starvation, twice back to back: the second run proves the counter restarted at 0
    starve_run("starve1", 64'h77);
    starve_run("starve2", 64'h78);
    idle();
    #1;
    check("starve perf", 64'(bus.perf_conflicts), perf_expect(exp_perf));

    // reset mid-activity: busy[3] set, B starved 2 cycles, then one reset cycle
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd3;
    tick();
    idle();
    bus.chk_addr1 = 5'd3;
    #1;
    check("pre-rst chk_busy1", 64'(bus.chk_busy1), 64'd1);
    bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 64'hA2;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 64'h77;
    tick();
    tick();
    check("pre-rst rf_wdata", bus.rf_wdata, 64'hA2);
    rst = 1'b1;
    #1;
    check("mid-rst a_ready", 64'(bus.a_ready), 64'd0);
    check("mid-rst b_ready", 64'(bus.b_ready), 64'd0);
    tick();
    rst = 1'b0;
    idle();
    bus.chk_addr1 = 5'd3;
    #1;
    check("post-rst rf_we", 64'(bus.rf_we), 64'd0);
    check("post-rst rf_waddr", 64'(bus.rf_waddr), 64'd0);
    check("post-rst rf_wdata", bus.rf_wdata, 64'd0);
    check("post-rst chk_busy1", 64'(bus.chk_busy1), 64'd0);
    check("post-rst perf", 64'(bus.perf_conflicts), 64'd0);

    // counter must start from 0 again; then one more conflict cycle makes 6
    exp_perf = 0;
    starve_run("post-rst starve", 64'h79);
    tick();
    exp_perf++;
    idle();
    #1;
    check("post-rst perf6", 64'(bus.perf_conflicts), perf_expect(exp_perf));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
